// File: rtl/data_mem_pipe_pkg.sv
// Shared types and constants for the pipelined data memory (data_mem_pipe).
// Optional byte-enable writes are selected with the DATA_MEM_BE_EN macro.
package data_mem_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } dmem_state_t;

   localparam int RD_LAT_MAX = 4;
   localparam int BYTE_W     = 8;

   function automatic int num_lanes(input int data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/data_mem_pipe_if.sv
// Request/response bundle between the load/store unit (master) and data_mem_pipe (slave).
// req_be exists only when DATA_MEM_BE_EN is defined.
interface data_mem_pipe_if #(
   parameter int DATA_W = 32
);
   // Handshake: a request transfers on a rising clk edge where req_valid and req_ready are
   // both 1; the master holds all req_* stable until then. Responses have no backpressure.
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [31:0]           req_addr;
   logic [DATA_W-1:0]     req_wdata;
`ifdef DATA_MEM_BE_EN
   logic [DATA_W/8-1:0]   req_be;
`endif
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  wr_drop;
   logic                  busy;

`ifdef DATA_MEM_BE_EN
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_drop, busy
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_drop, busy
   );
`else
   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_drop, busy
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_drop, busy
   );
`endif

endinterface

// File: rtl/data_mem_pipe_rd_pipe.sv
// Read-response delay line: RD_LAT stages of {valid, err, data}. Data/err of a stage only
// move when a valid entry passes, so the last stage holds its data between responses.
module dmem_rd_pipe
   import data_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic              i_err,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic              o_err,
   output logic [DATA_W-1:0] o_data
);

   localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

   logic [LAT-1:0]    r_vld;
   logic [LAT-1:0]    r_err;
   logic [DATA_W-1:0] r_dat [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_err <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_valid;
         if (i_valid) begin
            r_err[0] <= i_err;
            r_dat[0] <= i_data;
         end
         for (int i = 1; i < LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            if (r_vld[i-1]) begin
               r_err[i] <= r_err[i-1];
               r_dat[i] <= r_dat[i-1];
            end
         end
      end
   end

   assign o_valid = r_vld[LAT-1];
   assign o_err   = r_err[LAT-1];
   assign o_data  = r_dat[LAT-1];

endmodule

// File: rtl/data_mem_pipe.sv
// Word-addressed data memory for the MEM stage: valid/ready requests, RD_LAT read latency,
// post-reset clear sequencer, out-of-range detection. Byte enables with DATA_MEM_BE_EN.
module data_mem_pipe
   import data_mem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,   // must be below 32
   parameter int RD_LAT     = 1,
   parameter int CLR_ON_RST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   data_mem_pipe_if.slave   bus,
   output dmem_state_t      o_dbg_state
);

   localparam int          DEPTH   = 1 << ADDR_W;
   localparam int          LANES   = num_lanes(DATA_W);
   localparam dmem_state_t ST_RST  = (CLR_ON_RST != 0) ? ST_INIT : ST_RUN;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] CNT_END = {1'b1, {ADDR_W{1'b0}}};

   logic [DATA_W-1:0] r_mem [DEPTH];

   dmem_state_t       r_state;
   logic [ADDR_W:0]   r_clr_cnt;
   logic              r_busy;
   logic              r_req_ready;
   logic              r_wr_drop;

   logic [ADDR_W-1:0] w_idx;
   logic              w_oor;
   logic              w_acc;
   logic              w_wr_en;
   logic              w_rd_en;
   logic              w_clr_en;
   logic [ADDR_W:0]   w_clr_nxt;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_wmask;

   assign w_idx     = bus.req_addr[ADDR_W-1:0];
   assign w_oor     = |bus.req_addr[31:ADDR_W];
   assign w_acc     = bus.req_valid & r_req_ready;
   assign w_wr_en   = w_acc & bus.req_we & ~w_oor;
   assign w_rd_en   = w_acc & ~bus.req_we;
   assign w_clr_en  = (r_state == ST_INIT) & r_busy;
   assign w_clr_nxt = r_clr_cnt + CNT_ONE;
   assign w_rd_data = w_oor ? '0 : r_mem[w_idx];

`ifdef DATA_MEM_BE_EN
   always_comb begin
      w_wmask = '0;
      for (int i = 0; i < LANES; i++) begin
         w_wmask[i*BYTE_W +: BYTE_W] = {BYTE_W{bus.req_be[i]}};
      end
   end
`else
   always_comb begin
      w_wmask = '1;
   end
`endif

   // Clear and request writes never coincide: req_ready stays low throughout INIT.
   always_ff @(posedge clk) begin
      if (w_clr_en) begin
         r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (w_wr_en) begin
         r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (bus.req_wdata & w_wmask);
      end
   end

   // INIT spends its first cycle raising busy, then clears one word per cycle;
   // the extra counter bit flags the end of the sweep without wrapping to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RST;
         r_clr_cnt   <= '0;
         r_busy      <= 1'b0;
         r_req_ready <= 1'b0;
         r_wr_drop   <= 1'b0;
      end else begin
         r_wr_drop <= w_acc & bus.req_we & w_oor;
         case (r_state)
            ST_INIT: begin
               r_req_ready <= 1'b0;
               if (!r_busy) begin
                  r_busy <= 1'b1;
               end else begin
                  r_clr_cnt <= w_clr_nxt;
                  if (w_clr_nxt == CNT_END) begin
                     r_state     <= ST_RUN;
                     r_busy      <= 1'b0;
                     r_req_ready <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_RST;
            end
         endcase
      end
   end

   dmem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_rd_en),
      .i_err   (w_oor),
      .i_data  (w_rd_data),
      .o_valid (bus.rsp_valid),
      .o_err   (bus.rsp_err),
      .o_data  (bus.rsp_rdata)
   );

   assign bus.req_ready = r_req_ready;
   assign bus.busy      = r_busy;
   assign bus.wr_drop   = r_wr_drop;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe (ADDR_W=4, RD_LAT=3, clear on reset); exercises byte enables
// when built with DATA_MEM_BE_EN.
module tb_data_mem_pipe;
   import data_mem_pkg::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int RD_LAT = 3;
   localparam int DEPTH  = 16;
`ifdef DATA_MEM_BE_EN
   localparam bit BE_EN = 1'b1;
`else
   localparam bit BE_EN = 1'b0;
`endif

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          exp_err;
      logic [31:0] exp_data;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   dmem_state_t dbg_state;

   data_mem_pipe_if #(.DATA_W(DATA_W)) bus ();

   data_mem_pipe #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .RD_LAT     (RD_LAT),
      .CLR_ON_RST (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int          n_chk = 0;
   int          n_err = 0;
   int          ncyc  = 0;
   int          n_rsp = 0;
   logic [64:0] exp_q[$];      // {due negedge count, err, data}
   int          drop_q[$];     // due negedge count of wr_drop pulses
   logic [31:0] model_mem [DEPTH];
   logic [64:0] head;
   vec_t        tab [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      ncyc++;
      if (bus.rsp_valid) n_rsp++;
      if (exp_q.size() != 0 && int'(exp_q[0][64:33]) == ncyc) begin
         head = exp_q.pop_front();
         chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
         chk("rsp_err",   64'(bus.rsp_err),   64'(head[32]));
         chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(head[31:0]));
      end else if (bus.rsp_valid) begin
         chk("rsp_valid_unexpected", 64'(bus.rsp_valid), 64'd0);
      end
      if (drop_q.size() != 0 && drop_q[0] == ncyc) begin
         void'(drop_q.pop_front());
         chk("wr_drop", 64'(bus.wr_drop), 64'd1);
      end else if (bus.wr_drop) begin
         chk("wr_drop_unexpected", 64'(bus.wr_drop), 64'd0);
      end
   end

   // ---------------- reference model ----------------
   function automatic bit is_oor(input logic [31:0] a);
      return a >= 32'(DEPTH);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      return is_oor(a) ? 32'h0 : model_mem[a[3:0]];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
   endtask

   // ---------------- driver ----------------
   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit exp_err, input logic [31:0] exp_data);
      int guard;
      guard = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
`ifdef DATA_MEM_BE_EN
      bus.req_be    = be;
`endif
      while (!bus.req_ready && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!bus.req_ready) chk("req_ready_timeout", 64'(bus.req_ready), 64'd1);
      if (we) begin
         if (is_oor(addr)) begin
            drop_q.push_back(ncyc + 2);
         end else begin
            for (int i = 0; i < 4; i++)
               if (!BE_EN || be[i]) model_mem[addr[3:0]][8*i +: 8] = wdata[8*i +: 8];
         end
      end else begin
         exp_q.push_back({32'(ncyc + 1 + RD_LAT), exp_err, exp_data});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      chk({tag, "_busy"},      64'(bus.busy),      64'd0);
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
      chk({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
      chk({tag, "_wr_drop"},   64'(bus.wr_drop),   64'd0);
      chk({tag, "_state"},     64'(dbg_state),     64'(ST_INIT));
   endtask

   // Counts busy cycles from reset release until req_ready rises.
   task automatic measure_clear(input string tag);
      int busy_cnt;
      busy_cnt = 0;
      for (int g = 0; g < 100; g++) begin
         @(posedge clk);
         #1;
         if (bus.req_ready) break;
         if (bus.busy) busy_cnt++;
      end
      chk({tag, "_busy_cycles"}, 64'(busy_cnt),      64'(DEPTH));
      chk({tag, "_ready"},       64'(bus.req_ready), 64'd1);
      chk({tag, "_busy_end"},    64'(bus.busy),      64'd0);
      chk({tag, "_state_run"},   64'(dbg_state),     64'(ST_RUN));
      model_clear();
   endtask

   function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input bit exp_err, input logic [31:0] exp_data);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.be = 4'hF;
      v.exp_err = exp_err; v.exp_data = exp_data;
      return v;
   endfunction

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   endtask

   initial begin
      #1_000_000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      bit          w;
      int          n_rsp0;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
`ifdef DATA_MEM_BE_EN
      bus.req_be    = 4'h0;
`endif
      model_clear();

      tab[0]  = mk(1'b0, 32'd5,          32'h0,        1'b0, 32'h0);
      tab[1]  = mk(1'b1, 32'd3,          32'h0000_0400, 1'b0, 32'h0);
      tab[2]  = mk(1'b0, 32'd3,          32'h0,        1'b0, 32'h0000_0400);
      tab[3]  = mk(1'b1, 32'd0,          32'd31,       1'b0, 32'h0);
      tab[4]  = mk(1'b1, 32'd1,          32'd1024,     1'b0, 32'h0);
      tab[5]  = mk(1'b1, 32'd2,          32'd9,        1'b0, 32'h0);
      tab[6]  = mk(1'b0, 32'd0,          32'h0,        1'b0, 32'd31);
      tab[7]  = mk(1'b0, 32'd1,          32'h0,        1'b0, 32'd1024);
      tab[8]  = mk(1'b0, 32'd2,          32'h0,        1'b0, 32'd9);
      tab[9]  = mk(1'b0, 32'h10,         32'h0,        1'b1, 32'h0);
      tab[10] = mk(1'b1, 32'h10,         32'hDEAD_BEEF, 1'b0, 32'h0);
      tab[11] = mk(1'b0, 32'd0,          32'h0,        1'b0, 32'd31);
      tab[12] = mk(1'b1, 32'd15,         32'hA5A5_5A5A, 1'b0, 32'h0);
      tab[13] = mk(1'b0, 32'd15,         32'h0,        1'b0, 32'hA5A5_5A5A);
      tab[14] = mk(1'b0, 32'hFFFF_FFFF,  32'h0,        1'b1, 32'h0);
      tab[15] = mk(1'b0, 32'h8000_0003,  32'h0,        1'b1, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      measure_clear("clr1");

      // Back-to-back table vectors.
      for (int i = 0; i < 16; i++)
         drive(tab[i].we, tab[i].addr, tab[i].wdata, tab[i].be, tab[i].exp_err, tab[i].exp_data);
      idle(RD_LAT + 2);

`ifdef DATA_MEM_BE_EN
      drive(1'b1, 32'd6, 32'hFFFF_F800, 4'hF, 1'b0, 32'h0);
      drive(1'b1, 32'd6, 32'h0000_000A, 4'b0001, 1'b0, 32'h0);
      drive(1'b1, 32'd6, 32'h1234_5678, 4'b0000, 1'b0, 32'h0);
      drive(1'b0, 32'd6, 32'h0, 4'hF, 1'b0, 32'hFFFF_F80A);
      idle(RD_LAT + 2);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
               a = 32'($urandom_range(0, 15)) | (32'h1 << $urandom_range(4, 31));
            else
               a = 32'($urandom_range(0, 15));
            d = $urandom;
            b = BE_EN ? 4'($urandom_range(0, 15)) : 4'hF;
            drive(w, a, d, b, is_oor(a), model_read(a));
         end
      end
      idle(RD_LAT + 2);
      chk("drain_rsp_q",  64'(exp_q.size()),  64'd0);
      chk("drain_drop_q", 64'(drop_q.size()), 64'd0);

      // Reset with two reads in flight: both responses must vanish.
      drive(1'b1, 32'd7, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0);
      drive(1'b0, 32'd7, 32'h0, 4'hF, 1'b0, 32'h1357_9BDF);
      drive(1'b0, 32'd3, 32'h0, 4'hF, 1'b0, model_read(32'd3));
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      drop_q.delete();
      n_rsp0 = n_rsp;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      measure_clear("clr2");
      chk("no_rsp_after_reset", 64'(n_rsp - n_rsp0), 64'd0);

      // Every word must read back as zero after the second clear.
      for (int i = 0; i < DEPTH; i++)
         drive(1'b0, 32'(i), 32'h0, 4'hF, 1'b0, 32'h0);
      idle(RD_LAT + 2);
      chk("final_rsp_q", 64'(exp_q.size()), 64'd0);

      finish_run();
   end

endmodule
